// File: rtl/noc_out_port_arbiter.sv
// noc_out_port_arbiter
//   Shares one router output link among the N, E and L input FIFOs of a
//   router node. Round-robin arbitration between packets, wormhole locking
//   from head flit to tail flit, registered output stage.
//
//   Flit type lives in data[DATASIZE-1:DATASIZE-2]:
//     00 single, 01 head, 10 body, 11 tail.
//
// Ports
//   fifo_clk, rst_n            clock, async active-low reset
//   {N,E,L}_data_in            show-ahead head flit of each input FIFO
//   {N,E,L}_valid_in           FIFO non-empty
//   fifo_ready_{N,E,L}         combinational pop strobe back to each FIFO
//   data_out / valid_out       registered output flit, one-cycle valid
//   full_in                    downstream back-pressure, blocks all pops
//   grant_out                  one-hot owner {L,E,N}, 000 when not locked
//   busy                       arbiter holds a wormhole lock
//   err_out                    one-cycle pulse on a flit-type protocol error

// Per-input pop/classify slice. The upper type bit marks a flit that belongs
// inside a packet (body/tail); whether that is legal depends on lock state.
module noc_out_port_arbiter_lane (
    input  logic rst_n,
    input  logic sel,
    input  logic valid,
    input  logic full,
    input  logic locked,
    input  logic cont,
    output logic pop,
    output logic fwd,
    output logic err
);
    // Gated by rst_n so nothing is popped while the node is held in reset.
    assign pop = rst_n & sel & valid & ~full;

    // IDLE: body/tail is dropped and flagged.
    // LOCKED: everything is forwarded; single/head is flagged.
    assign fwd = pop & (locked | ~cont);
    assign err = pop & (locked ? ~cont : cont);
endmodule

module noc_out_port_arbiter #(
    parameter int DATASIZE = 40
) (
    input  logic                fifo_clk,
    input  logic                rst_n,
    input  logic [DATASIZE-1:0] N_data_in,
    input  logic                N_valid_in,
    output logic                fifo_ready_N,
    input  logic [DATASIZE-1:0] E_data_in,
    input  logic                E_valid_in,
    output logic                fifo_ready_E,
    input  logic [DATASIZE-1:0] L_data_in,
    input  logic                L_valid_in,
    output logic                fifo_ready_L,
    output logic [DATASIZE-1:0] data_out,
    output logic                valid_out,
    input  logic                full_in,
    output logic [2:0]          grant_out,
    output logic                busy,
    output logic                err_out
);
    localparam int NUM_IN = 3;

    localparam logic [1:0] T_SINGLE = 2'b00;
    localparam logic [1:0] T_HEAD   = 2'b01;
    localparam logic [1:0] T_TAIL   = 2'b11;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Rotate an input index by off positions modulo NUM_IN.
    function automatic logic [1:0] rr_idx(input logic [1:0] base, input logic [1:0] off);
        logic [2:0] s;
        s = {1'b0, base} + {1'b0, off};
        if (s >= 3'(NUM_IN)) s = s - 3'(NUM_IN);
        return s[1:0];
    endfunction

    function automatic logic [NUM_IN-1:0] onehot(input logic [1:0] idx);
        logic [NUM_IN-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    // Inputs gathered into index order 0=N, 1=E, 2=L.
    logic [NUM_IN-1:0][DATASIZE-1:0] din;
    logic [NUM_IN-1:0]               vin;
    logic [NUM_IN-1:0]               cont;

    assign din = {L_data_in, E_data_in, N_data_in};
    assign vin = {L_valid_in, E_valid_in, N_valid_in};

    for (genvar i = 0; i < NUM_IN; i++) begin : g_cont
        assign cont[i] = din[i][DATASIZE-1];
    end

    state_t     state, state_nxt;
    logic [1:0] owner, owner_nxt;   // input holding the wormhole lock
    logic [1:0] ptr, ptr_nxt;       // highest-priority input for next IDLE pick

    logic [1:0]        win;
    logic              win_vld;
    logic [NUM_IN-1:0] sel;
    logic [NUM_IN-1:0] pop, lane_fwd, lane_err;
    logic              any_pop, fwd, err;
    logic [DATASIZE-1:0] pdata;
    logic [1:0]        ptype;

    // Round-robin pick: scan from the lowest priority upward so the last
    // valid hit is the first requester at or after ptr.
    always_comb begin
        logic [1:0] idx;
        win     = ptr;
        win_vld = 1'b0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            idx = rr_idx(ptr, 2'(k));
            if (vin[idx]) begin
                win     = idx;
                win_vld = 1'b1;
            end
        end
    end

    noc_out_port_arbiter_lane u_lane [NUM_IN-1:0] (
        .rst_n  (rst_n),
        .sel    (sel),
        .valid  (vin),
        .full   (full_in),
        .locked (state == LOCKED),
        .cont   (cont),
        .pop    (pop),
        .fwd    (lane_fwd),
        .err    (lane_err)
    );

    assign fifo_ready_N = pop[0];
    assign fifo_ready_E = pop[1];
    assign fifo_ready_L = pop[2];

    // pop is one-hot or zero, so an AND-OR mux is enough.
    always_comb begin
        pdata = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (pop[i]) pdata = pdata | din[i];
        end
    end

    assign ptype   = pdata[DATASIZE-1 -: 2];
    assign any_pop = |pop;
    assign fwd     = |lane_fwd;
    assign err     = |lane_err;

    // FSM: state register
    always_ff @(posedge fifo_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            owner <= 2'd0;
            ptr   <= 2'd0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        ptr_nxt   = ptr;
        if (any_pop) begin
            unique case (state)
                IDLE: begin
                    if (ptype == T_HEAD) begin
                        // Pointer moves only when the packet ends.
                        state_nxt = LOCKED;
                        owner_nxt = win;
                    end else begin
                        // Single, or a dropped stray body/tail.
                        ptr_nxt = rr_idx(win, 2'd1);
                    end
                end
                LOCKED: begin
                    if (ptype == T_TAIL) begin
                        state_nxt = IDLE;
                        ptr_nxt   = rr_idx(owner, 2'd1);
                    end
                end
                default: ;
            endcase
        end
    end

    // FSM: outputs (input select)
    always_comb begin
        sel = '0;
        unique case (state)
            IDLE:    sel = win_vld ? onehot(win) : '0;
            LOCKED:  sel = onehot(owner);
            default: sel = '0;
        endcase
    end

    // Registered output stage. grant/busy follow the state being entered so
    // they line up with the state register.
    always_ff @(posedge fifo_clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out  <= '0;
            valid_out <= 1'b0;
            err_out   <= 1'b0;
            grant_out <= '0;
            busy      <= 1'b0;
        end else begin
            valid_out <= fwd;
            err_out   <= err;
            if (fwd) data_out <= pdata;
            busy      <= (state_nxt == LOCKED);
            grant_out <= (state_nxt == LOCKED) ? onehot(owner_nxt) : '0;
        end
    end

    // Single-flit type is the reset-style default; kept named for readers.
    logic unused_ok;
    assign unused_ok = (T_SINGLE == 2'b00);
endmodule

// File: tb/tb_noc_out_port_arbiter.sv
module tb_noc_out_port_arbiter;
    localparam int DW = 40;

    logic          fifo_clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] N_data_in, E_data_in, L_data_in;
    logic          N_valid_in, E_valid_in, L_valid_in;
    logic          fifo_ready_N, fifo_ready_E, fifo_ready_L;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          full_in;
    logic [2:0]    grant_out;
    logic          busy;
    logic          err_out;

    always #5 fifo_clk = ~fifo_clk;

    noc_out_port_arbiter #(.DATASIZE(DW)) dut (
        .fifo_clk     (fifo_clk),
        .rst_n        (rst_n),
        .N_data_in    (N_data_in),
        .N_valid_in   (N_valid_in),
        .fifo_ready_N (fifo_ready_N),
        .E_data_in    (E_data_in),
        .E_valid_in   (E_valid_in),
        .fifo_ready_E (fifo_ready_E),
        .L_data_in    (L_data_in),
        .L_valid_in   (L_valid_in),
        .fifo_ready_L (fifo_ready_L),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .full_in      (full_in),
        .grant_out    (grant_out),
        .busy         (busy),
        .err_out      (err_out)
    );

    // Show-ahead FIFO models: 0=N, 1=E, 2=L. cnt is written by the stimulus,
    // head by the pop process; both return to 0 on reset.
    logic [DW-1:0] mem [3][32];
    int            head [3];
    int            cnt  [3];

    assign N_data_in  = mem[0][head[0][4:0]];
    assign E_data_in  = mem[1][head[1][4:0]];
    assign L_data_in  = mem[2][head[2][4:0]];
    assign N_valid_in = head[0] < cnt[0];
    assign E_valid_in = head[1] < cnt[1];
    assign L_valid_in = head[2] < cnt[2];

    wire [2:0] rdy = {fifo_ready_L, fifo_ready_E, fifo_ready_N};

    always @(posedge fifo_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) head[i] <= 0;
        end else begin
            if (fifo_ready_N) head[0] <= head[0] + 1;
            if (fifo_ready_E) head[1] <= head[1] + 1;
            if (fifo_ready_L) head[2] <= head[2] + 1;
        end
    end

    int vecs = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vecs++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(input logic [1:0] t, input int id);
        return {t, (DW-2)'(id)};
    endfunction

    task automatic push(input int p, input logic [1:0] t, input int id);
        mem[p][cnt[p][4:0]] = mk(t, id);
        cnt[p] = cnt[p] + 1;
    endtask

    task automatic cyc();
        @(negedge fifo_clk);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) cnt[i] = 0;
        rst_n   = 1'b0;
        full_in = 1'b0;

        // Reset with every input requesting
        push(0, 2'b00, 1); push(0, 2'b00, 4);
        push(1, 2'b00, 2); push(1, 2'b00, 5);
        push(2, 2'b00, 3); push(2, 2'b00, 6);
        cyc(); #1;
        chk("rst_rdy", 64'(rdy), 64'b000);
        chk("rst_vld", 64'(valid_out), 64'd0);
        chk("rst_gnt", 64'(grant_out), 64'b000);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_data", 64'(data_out), 64'd0);
        chk("rst_err", 64'(err_out), 64'd0);
        cyc(); rst_n = 1'b1; #1;
        chk("rel_rdy", 64'(rdy), 64'b001);

        // Round-robin over single flits
        cyc(); #1;
        chk("rr1_rdy", 64'(rdy), 64'b010);
        chk("rr1_vld", 64'(valid_out), 64'd1);
        chk("rr1_data", 64'(data_out), 64'(mk(2'b00, 1)));
        cyc(); #1;
        chk("rr2_rdy", 64'(rdy), 64'b100);
        chk("rr2_data", 64'(data_out), 64'(mk(2'b00, 2)));
        cyc(); #1;
        chk("rr3_rdy", 64'(rdy), 64'b001);
        chk("rr3_data", 64'(data_out), 64'(mk(2'b00, 3)));
        cyc(); #1;
        chk("rr4_rdy", 64'(rdy), 64'b010);
        chk("rr4_data", 64'(data_out), 64'(mk(2'b00, 4)));
        cyc(); #1;
        chk("rr5_rdy", 64'(rdy), 64'b100);
        chk("rr5_data", 64'(data_out), 64'(mk(2'b00, 5)));
        cyc(); #1;
        chk("rr6_rdy", 64'(rdy), 64'b000);
        chk("rr6_vld", 64'(valid_out), 64'd1);
        chk("rr6_data", 64'(data_out), 64'(mk(2'b00, 6)));
        cyc(); #1;
        chk("rr_end_vld", 64'(valid_out), 64'd0);

        // E packet locks the link while N waits
        cyc();
        push(1, 2'b01, 10); push(1, 2'b10, 11); push(1, 2'b10, 12); push(1, 2'b11, 13);
        #1;
        chk("e_h_rdy", 64'(rdy), 64'b010);
        chk("e_h_gnt", 64'(grant_out), 64'b000);
        cyc();
        push(0, 2'b00, 20); push(0, 2'b00, 21);
        #1;
        chk("e_b1_rdy", 64'(rdy), 64'b010);
        chk("e_b1_gnt", 64'(grant_out), 64'b010);
        chk("e_b1_busy", 64'(busy), 64'd1);
        chk("e_b1_data", 64'(data_out), 64'(mk(2'b01, 10)));
        cyc(); #1;
        chk("e_b2_rdy", 64'(rdy), 64'b010);
        chk("e_b2_gnt", 64'(grant_out), 64'b010);
        chk("e_b2_data", 64'(data_out), 64'(mk(2'b10, 11)));
        cyc(); #1;
        chk("e_t_rdy", 64'(rdy), 64'b010);
        chk("e_t_gnt", 64'(grant_out), 64'b010);
        chk("e_t_data", 64'(data_out), 64'(mk(2'b10, 12)));
        cyc(); #1;
        chk("e_n1_rdy", 64'(rdy), 64'b001);
        chk("e_n1_gnt", 64'(grant_out), 64'b000);
        chk("e_n1_busy", 64'(busy), 64'd0);
        chk("e_n1_data", 64'(data_out), 64'(mk(2'b11, 13)));
        cyc(); #1;
        chk("e_n2_rdy", 64'(rdy), 64'b001);
        chk("e_n2_data", 64'(data_out), 64'(mk(2'b00, 20)));
        cyc(); #1;
        chk("e_end_rdy", 64'(rdy), 64'b000);
        chk("e_end_data", 64'(data_out), 64'(mk(2'b00, 21)));

        // L packet stalled by full_in for three cycles
        cyc();
        push(2, 2'b01, 30); push(2, 2'b10, 31); push(2, 2'b10, 32); push(2, 2'b11, 33);
        #1;
        chk("l_h_rdy", 64'(rdy), 64'b100);
        cyc(); #1;
        chk("l_b1_rdy", 64'(rdy), 64'b100);
        chk("l_b1_gnt", 64'(grant_out), 64'b100);
        chk("l_b1_data", 64'(data_out), 64'(mk(2'b01, 30)));
        cyc(); full_in = 1'b1; #1;
        chk("l_f1_rdy", 64'(rdy), 64'b000);
        chk("l_f1_vld", 64'(valid_out), 64'd1);
        chk("l_f1_data", 64'(data_out), 64'(mk(2'b10, 31)));
        cyc(); #1;
        chk("l_f2_rdy", 64'(rdy), 64'b000);
        chk("l_f2_vld", 64'(valid_out), 64'd0);
        chk("l_f2_gnt", 64'(grant_out), 64'b100);
        chk("l_f2_busy", 64'(busy), 64'd1);
        cyc(); #1;
        chk("l_f3_rdy", 64'(rdy), 64'b000);
        chk("l_f3_vld", 64'(valid_out), 64'd0);
        chk("l_f3_gnt", 64'(grant_out), 64'b100);
        cyc(); full_in = 1'b0; #1;
        chk("l_r_rdy", 64'(rdy), 64'b100);
        chk("l_r_vld", 64'(valid_out), 64'd0);
        chk("l_r_gnt", 64'(grant_out), 64'b100);
        chk("l_r_data", 64'(data_out), 64'(mk(2'b10, 31)));
        cyc(); #1;
        chk("l_t_rdy", 64'(rdy), 64'b100);
        chk("l_t_data", 64'(data_out), 64'(mk(2'b10, 32)));
        cyc(); #1;
        chk("l_end_rdy", 64'(rdy), 64'b000);
        chk("l_end_data", 64'(data_out), 64'(mk(2'b11, 33)));
        chk("l_end_gnt", 64'(grant_out), 64'b000);

        // Stray body flit while IDLE is dropped and flagged
        cyc();
        push(0, 2'b10, 40);
        #1;
        chk("s_rdy", 64'(rdy), 64'b001);
        cyc(); #1;
        chk("s_err", 64'(err_out), 64'd1);
        chk("s_vld", 64'(valid_out), 64'd0);
        chk("s_busy", 64'(busy), 64'd0);
        chk("s_gnt", 64'(grant_out), 64'b000);
        chk("s_data", 64'(data_out), 64'(mk(2'b11, 33)));
        cyc(); #1;
        chk("s_err_clr", 64'(err_out), 64'd0);

        // Single flit inside a locked packet: forwarded and flagged
        cyc();
        push(1, 2'b01, 50); push(1, 2'b00, 51); push(1, 2'b11, 52);
        #1;
        chk("k_h_rdy", 64'(rdy), 64'b010);
        cyc(); #1;
        chk("k_h_data", 64'(data_out), 64'(mk(2'b01, 50)));
        chk("k_h_err", 64'(err_out), 64'd0);
        cyc(); #1;
        chk("k_s_data", 64'(data_out), 64'(mk(2'b00, 51)));
        chk("k_s_vld", 64'(valid_out), 64'd1);
        chk("k_s_err", 64'(err_out), 64'd1);
        chk("k_s_busy", 64'(busy), 64'd1);
        cyc(); #1;
        chk("k_t_data", 64'(data_out), 64'(mk(2'b11, 52)));
        chk("k_t_err", 64'(err_out), 64'd0);
        chk("k_t_gnt", 64'(grant_out), 64'b000);

        // Reset while locked on E
        cyc();
        push(1, 2'b01, 60); push(1, 2'b10, 61); push(1, 2'b10, 62);
        #1;
        chk("r_h_rdy", 64'(rdy), 64'b010);
        cyc(); #1;
        chk("r_lk_busy", 64'(busy), 64'd1);
        chk("r_lk_gnt", 64'(grant_out), 64'b010);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) cnt[i] = 0;
        #1;
        chk("r_busy", 64'(busy), 64'd0);
        chk("r_gnt", 64'(grant_out), 64'b000);
        chk("r_rdy", 64'(rdy), 64'b000);
        chk("r_vld", 64'(valid_out), 64'd0);
        cyc();
        push(0, 2'b00, 70); push(1, 2'b00, 71); push(2, 2'b00, 72);
        #1;
        chk("r_hold_rdy", 64'(rdy), 64'b000);
        cyc(); rst_n = 1'b1; #1;
        chk("r_rel_rdy", 64'(rdy), 64'b001);
        cyc(); #1;
        chk("r_2_rdy", 64'(rdy), 64'b010);
        chk("r_2_data", 64'(data_out), 64'(mk(2'b00, 70)));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end
endmodule
